systolic_feeder: RTL

- Drives the input side of the 16x16 weight-stationary systolic array.
- Takes a command, an upstream weight-row stream and an activation-vector stream, and produces the array's control and data inputs:
  - load_weights, weight_row, weight_in
  - clear_acc, start_compute
  - column-skewed activation_in and activation_valid
- Sits between the tile buffer/DMA and the array inside the GEMM engine. Owns all sequencing so the array only sees legal control sequences.

---
 rtl/systolic_feeder.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
// Input-side sequencer for a weight-stationary systolic array: weight loading,
// clear/start control and column-skewed activation streaming.
module systolic_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_SIZE = 16,
  parameter int CNT_W      = $clog2(ARRAY_SIZE) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_load_weights,
  input  logic [CNT_W-1:0]      cmd_num_vecs,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DATA_WIDTH-1:0] w_data [ARRAY_SIZE],
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [DATA_WIDTH-1:0] a_data [ARRAY_SIZE],
  input  logic                  sa_busy,
  output logic                  load_weights,
  output logic [$clog2(ARRAY_SIZE)-1:0] weight_row,
  output logic [DATA_WIDTH-1:0] weight_in [ARRAY_SIZE],
  output logic                  clear_acc,
  output logic                  start_compute,
  output logic [DATA_WIDTH-1:0] activation_in [ARRAY_SIZE],
  output logic                  activation_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int RW = $clog2(ARRAY_SIZE);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_W    = 3'd1,
    CLEAR     = 3'd2,
    START     = 3'd3,
    STREAM    = 3'd4,
    DRAIN     = 3'd5,
    WAIT_BUSY = 3'd6
  } state_t;

  state_t           state, state_nxt;
  logic [RW-1:0]    row, row_nxt;
  logic [RW-1:0]    drain_cnt, drain_nxt;
  logic [CNT_W-1:0] vec_cnt, vec_nxt;
  logic [CNT_W-1:0] n_vecs, n_nxt;
  logic             shift;
  logic             head_live;
  logic             act_valid;

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      drain_cnt <= '0;
      vec_cnt   <= '0;
      n_vecs    <= '0;
      act_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      row       <= row_nxt;
      drain_cnt <= drain_nxt;
      vec_cnt   <= vec_nxt;
      n_vecs    <= n_nxt;
      act_valid <= shift;
    end
  end

  // Next-state logic and array/handshake strobes
  always_comb begin
    state_nxt     = state;
    row_nxt       = row;
    drain_nxt     = drain_cnt;
    vec_nxt       = vec_cnt;
    n_nxt         = n_vecs;
    cmd_ready     = 1'b0;
    w_ready       = 1'b0;
    a_ready       = 1'b0;
    load_weights  = 1'b0;
    weight_row    = '0;
    clear_acc     = 1'b0;
    start_compute = 1'b0;
    done          = 1'b0;
    shift         = 1'b0;
    head_live     = 1'b0;
    for (int c = 0; c < ARRAY_SIZE; c++) begin
      weight_in[c] = '0;
    end

    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          vec_nxt = '0;
          // A zero or oversized count means a full tile of vectors.
          if ((cmd_num_vecs == '0) || (cmd_num_vecs > CNT_W'(ARRAY_SIZE))) begin
            n_nxt = CNT_W'(ARRAY_SIZE);
          end else begin
            n_nxt = cmd_num_vecs;
          end
          if (cmd_load_weights) begin
            state_nxt = LOAD_W;
          end else begin
            state_nxt = CLEAR;
          end
        end else begin
          state_nxt = IDLE;
        end
      end

      LOAD_W: begin
        w_ready      = 1'b1;
        load_weights = w_valid;
        weight_row   = row;
        for (int c = 0; c < ARRAY_SIZE; c++) begin
          weight_in[c] = w_data[c];
        end
        if (w_valid) begin
          if (row == RW'(ARRAY_SIZE - 1)) begin
            row_nxt   = '0;
            state_nxt = CLEAR;
          end else begin
            row_nxt = row + RW'(1);
          end
        end else begin
          row_nxt = row;
        end
      end

      CLEAR: begin
        clear_acc = 1'b1;
        state_nxt = START;
      end

      START: begin
        start_compute = 1'b1;
        state_nxt     = STREAM;
      end

      STREAM: begin
        head_live = 1'b1;
        a_ready   = (vec_cnt < n_vecs);
        if (a_valid && a_ready) begin
          shift   = 1'b1;
          vec_nxt = vec_cnt + CNT_W'(1);
          if (vec_cnt == (n_vecs - CNT_W'(1))) begin
            drain_nxt = '0;
            state_nxt = DRAIN;
          end else begin
            state_nxt = STREAM;
          end
        end else begin
          state_nxt = STREAM;
        end
      end

      DRAIN: begin
        shift = 1'b1;
        if (drain_cnt == RW'(ARRAY_SIZE - 2)) begin
          state_nxt = WAIT_BUSY;
        end else begin
          drain_nxt = drain_cnt + RW'(1);
        end
      end

      WAIT_BUSY: begin
        if (!sa_busy) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_BUSY;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy             = (state != IDLE);
  assign activation_valid = act_valid;

  // Column c delays its element by c extra cycles so the array sees a diagonal wavefront.
  for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col
    logic [DATA_WIDTH-1:0] line [c+1];

    // Skew chain for this column; advances only on shift events
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= c; k++) begin
          line[k] <= '0;
        end
      end else if (shift) begin
        line[0] <= head_live ? a_data[c] : '0;
        for (int k = 1; k <= c; k++) begin
          line[k] <= line[k-1];
        end
      end
    end

    assign activation_in[c] = line[c];
  end

endmodule
